// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - multi-cycle HI/LO multiply/divide sequencer
// Ports: clk, rst (sync, active-low); start/op/rs_data/rt_data issue an md op;
//        hilo_use marks an instruction needing HI/LO; flush aborts the op;
//        busy/stall report occupancy; done pulses with hi_out/lo_out/div_zero.
module md_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             hilo_use,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_FIX, S_ZERO, S_DONE} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      count;
  logic               is_div, neg_lo, neg_hi;
  logic [WIDTH-1:0]   opb;
  // Multiply: {carry+upper (WIDTH+1), multiplier/low product (WIDTH)}.
  // Divide:   {spare bit, remainder (WIDTH), quotient (WIDTH)}.
  logic [2*WIDTH:0]   acc;

  logic               accept, rt_zero;
  logic [WIDTH-1:0]   abs_a, abs_b, acc_init;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_step, div_sh, div_step;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_sgn;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign accept  = start & ~flush & ((state == S_IDLE) | (state == S_DONE));
  assign rt_zero = (rt_data == '0);
  assign abs_a   = (op[0] & rs_data[WIDTH-1]) ? -rs_data : rs_data;
  assign abs_b   = (op[0] & rt_data[WIDTH-1]) ? -rt_data : rt_data;
  // A zero divisor skips CALC, so the raw dividend is parked for ZERO to return.
  assign acc_init = op[1] ? (rt_zero ? rs_data : abs_a) : abs_b;

  assign mul_sum  = acc[2*WIDTH:WIDTH] + {1'b0, opb};
  assign mul_step = acc[0] ? {1'b0, mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH:1]};

  assign div_sh   = {acc[2*WIDTH-1:0], 1'b0};
  assign div_ge   = div_sh[2*WIDTH:WIDTH] >= {1'b0, opb};
  // Only the low WIDTH bits of the difference matter: when it is kept it is below opb.
  assign div_diff = div_sh[2*WIDTH-1:WIDTH] - opb;
  assign div_step = div_ge ? {1'b0, div_diff, div_sh[WIDTH-1:1], 1'b1} : div_sh;

  assign prod_sgn = neg_lo ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
  assign res_hi   = is_div ? (neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                           : prod_sgn[2*WIDTH-1:WIDTH];
  assign res_lo   = is_div ? (neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])
                           : prod_sgn[WIDTH-1:0];

  assign busy  = (state == S_CALC) | (state == S_FIX) | (state == S_ZERO);
  assign stall = busy & hilo_use;
  assign done  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) state_nxt = (op[1] && rt_zero) ? S_ZERO : S_CALC;
        else        state_nxt = S_IDLE;
      end
      S_CALC: begin
        if (flush)                          state_nxt = S_IDLE;
        else if (count == CW'(WIDTH - 1))   state_nxt = S_FIX;
      end
      S_FIX, S_ZERO: state_nxt = flush ? S_IDLE : S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      acc      <= '0;
      opb      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            count  <= '0;
            is_div <= op[1];
            neg_lo <= op[0] & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_hi <= op[0] & rs_data[WIDTH-1];
            opb    <= op[1] ? abs_b : abs_a;
            acc    <= {{(WIDTH+1){1'b0}}, acc_init};
          end
        end
        S_CALC: begin
          count <= count + CW'(1);
          acc   <= is_div ? div_step : mul_step;
        end
        S_FIX: begin
          if (!flush) begin
            hi_out   <= res_hi;
            lo_out   <= res_lo;
            div_zero <= 1'b0;
          end
        end
        S_ZERO: begin
          if (!flush) begin
            hi_out   <= acc[WIDTH-1:0];
            lo_out   <= '1;
            div_zero <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb/tb_md_sequencer.sv - self-checking bench for md_sequencer
module tb_md_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, hilo_use, flush;
  logic [1:0]   op;
  logic [W-1:0] rs_data, rt_data;
  logic         busy, stall, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  md_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs_data(rs_data), .rt_data(rt_data),
    .hilo_use(hilo_use), .flush(flush), .busy(busy), .stall(stall), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        use_hl;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit arithmetic on the architectural rules.
  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (o)
      2'd0: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (o == 2'd2) begin
          lo = a / b; hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          lo = q[31:0]; hi = r[31:0];
        end
      end
    endcase
  endtask

  // Issues one op, then follows it cycle by cycle until done; returns in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic use_hl, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int elat, input string tag);
    int   n, bad;
    logic got, exp_b;
    op = o; rs_data = a; rt_data = b; start = 1'b1; hilo_use = use_hl;
    tick;
    start = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    n = 0; bad = 0; got = 1'b0;
    while (!got && n < 60) begin
      n++;
      exp_b = (n < elat);
      if (busy !== exp_b || stall !== (exp_b & use_hl)) bad++;
      if (done === 1'b1) got = 1'b1;
      else tick;
    end
    if (!got) n = 999;
    check({tag, " latency"}, 64'(n), 64'(elat));
    check({tag, " busy/stall profile errors"}, 64'(bad), 64'd0);
    check({tag, " hi"}, 64'(hi_out), 64'(eh));
    check({tag, " lo"}, 64'(lo_out), 64'(el));
    check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    hilo_use = 1'b0;
  endtask

  task automatic watch_no_done(input string tag);
    logic seen;
    seen = 1'b0;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      tick;
    end
    check({tag, " stays idle"}, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] mh, ml, a, b;
    logic        mdz;
    logic [1:0]  o;

    vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFD, 32'd5,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, 34};
    vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[3]  = '{2'd2, 32'd100,       32'd7,         1'b1, 32'd2,         32'd14,        1'b0, 34};
    vecs[4]  = '{2'd2, 32'd5,         32'd0,         1'b1, 32'd5,         32'hFFFF_FFFF, 1'b1, 2};
    vecs[5]  = '{2'd0, 32'd0,         32'd1234,      1'b0, 32'd0,         32'd0,         1'b0, 34};
    vecs[6]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'd0,         1'b0, 34};
    vecs[7]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0,         32'h8000_0000, 1'b0, 34};
    vecs[8]  = '{2'd3, 32'hFFFF_FFF9, 32'd0,         1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 2};
    vecs[9]  = '{2'd2, 32'd7,         32'd100,       1'b0, 32'd7,         32'd0,         1'b0, 34};
    vecs[10] = '{2'd3, 32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         32'hFFFF_FFFD, 1'b0, 34};
    vecs[11] = '{2'd1, 32'd7,         32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF2, 1'b0, 34};

    rst = 1'b0; start = 1'b0; hilo_use = 1'b1; flush = 1'b0; op = 2'd0;
    rs_data = '0; rt_data = '0;
    tick; tick;
    check("reset busy", 64'(busy), 64'd0);
    check("reset stall", 64'(stall), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset hi", 64'(hi_out), 64'd0);
    check("reset lo", 64'(lo_out), 64'd0);
    check("reset div_zero", 64'(div_zero), 64'd0);
    rst = 1'b1; hilo_use = 1'b0;
    tick;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].use_hl, vecs[i].hi, vecs[i].lo,
             vecs[i].dz, vecs[i].lat, $sformatf("vec%0d", i));
      tick;
      check($sformatf("vec%0d done one cycle", i), 64'(done), 64'd0);
    end

    // Flush mid-divide: no done, results untouched.
    run_op(2'd2, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 34, "pre_flush");
    tick;
    op = 2'd3; rs_data = 32'h1234_5678; rt_data = 32'd3; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    check("flush done", 64'(done), 64'd0);
    watch_no_done("flush");
    check("flush hi kept", 64'(hi_out), 64'd2);
    check("flush lo kept", 64'(lo_out), 64'd14);

    // Reset mid-divide after a divide-by-zero left non-zero state.
    run_op(2'd2, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1'b1, 2, "pre_reset");
    tick;
    op = 2'd3; rs_data = 32'h0000_1000; rt_data = 32'd9; start = 1'b1;
    tick;
    start = 1'b0; hilo_use = 1'b1;
    repeat (9) tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst stall", 64'(stall), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst hi", 64'(hi_out), 64'd0);
    check("midrst lo", 64'(lo_out), 64'd0);
    check("midrst div_zero", 64'(div_zero), 64'd0);
    hilo_use = 1'b0;
    watch_no_done("midrst");

    // start together with flush in IDLE is dropped.
    op = 2'd0; rs_data = 32'd3; rt_data = 32'd4; start = 1'b1; flush = 1'b1;
    tick;
    start = 1'b0; flush = 1'b0;
    check("start+flush busy", 64'(busy), 64'd0);
    watch_no_done("start+flush");

    // Back-to-back: second op issued in the done cycle of the first.
    run_op(2'd2, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 34, "b2b_first");
    run_op(2'd0, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 1'b0, 34, "b2b_second");
    tick;

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = 32'h8000_0000;
        1: a = 32'($urandom_range(0, 255));
        2: a = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      model(o, a, b, mh, ml, mdz);
      run_op(o, a, b, 1'($urandom_range(0, 1)), mh, ml, mdz, mdz ? 2 : 34,
             $sformatf("rand%0d op%0d %h/%h", i, o, a, b));
      if (i % 3 != 0) tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
- Multi-cycle controller for the CPU's HI/LO arithmetic: accepts MULT/MULTU/DIV/DIVU from the decoder and runs a 1-bit-per-cycle shift-add multiply or restoring divide.
- Presents the 64-bit result as a one-cycle `done` pulse to the lohi register block.
- Produces `stall` to freeze the PC register when a later instruction needs HI/LO, or issues another md op, while the unit is busy.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH (HI:LO). Counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  system clock (same clock as PC/Regfiles)
- rst  in  1  synchronous reset, active-low
- start  in  1  decoder asserts for one md instruction (MULT/MULTU/DIV/DIVU)
- op  in  2  00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed)
- rs_data  in  WIDTH  multiplicand / dividend
- rt_data  in  WIDTH  multiplier / divisor
- hilo_use  in  1  current instruction is MFHI/MFLO/MTHI/MTLO or another md op
- flush  in  1  exception/ERET taken; abort current operation
- busy  out  1  operation in progress
- stall  out  1  busy & hilo_use; holds PC and suppresses RF/DM writes
- done  out  1  one-cycle pulse; hi_out/lo_out valid
- hi_out  out  WIDTH  HI result (remainder for divide), registered, held until next done
- lo_out  out  WIDTH  LO result (quotient for divide), registered, held until next done
- div_zero  out  1  with done: divide issued with rt_data==0

Behaviour:
- Reset (rst==0 at posedge): state=IDLE; busy=0, done=0, div_zero=0, hi_out=0, lo_out=0, counter=0. Reset wins over everything, including mid-operation.
- State IDLE:
  - On start&!flush: latch op and operands.
  - Signed ops store the absolute values plus the result-sign flags: quotient/product sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
  - Divide with rt_data==0 -> ZERO; otherwise -> CALC with counter=0.
- State CALC: busy=1; one iteration per cycle.
  - Multiply: if multiplier LSB set, add multiplicand to the upper half of a 2*WIDTH accumulator, then shift right 1 (carry kept; accumulator is WIDTH+1 bits in the upper half).
  - Divide: shift remainder:quotient left 1; trial-subtract the divisor from the remainder. If non-negative, keep it and set quotient LSB=1; else restore.
  - Exactly WIDTH cycles; counter==WIDTH-1 -> FIX.
- State FIX (1 cycle, busy=1): apply two's-complement negation per the sign flags (signed ops only), write hi_out/lo_out, -> DONE.
- State ZERO (1 cycle, busy=1): hi_out=rs_data (latched), lo_out={WIDTH{1'b1}}, -> DONE with div_zero=1.
- State DONE (1 cycle): done=1, busy=0, -> IDLE. A start in DONE is accepted exactly as in IDLE (back-to-back ops).
- Latency: start sampled at edge k -> done high during cycle k+WIDTH+2 (34 for WIDTH=32). Divide-by-zero: done at k+2.
- busy is high from cycle k+1 until the cycle before done.
- stall is combinational: busy & hilo_use. It is never asserted in IDLE or DONE.
- start while busy: ignored. The CPU cannot issue it, since an md op sets hilo_use and is therefore stalled.
- flush:
  - In CALC/FIX/ZERO: -> IDLE next edge; hi_out/lo_out unchanged; no done pulse.
  - With start in IDLE: flush wins, op not accepted.
- Signed edge cases:
  - MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
  - DIV 0x80000000 / -1 -> LO=0x80000000, HI=0 (wraps; no trap).
- done, div_zero and hi/lo update only via DONE; div_zero clears on the next done without a zero divisor.

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> done at cycle k+34; HI=0xFFFFFFFE, LO=0x00000001; busy high for cycles k+1..k+33.
- MULT rs=0xFFFFFFFD (-3) rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=100 rt=7 -> LO=14, HI=2. DIVU rs=5 rt=0 -> done at k+2, div_zero=1, LO=0xFFFFFFFF, HI=5.
- Issue DIVU, then hold hilo_use=1 (MFLO) from k+1 -> stall=1 for cycles k+1..k+33, 0 in the done cycle. With hilo_use=0, stall stays 0 throughout.
- Start DIV, assert flush at k+10 -> IDLE at k+11, no done, hi/lo keep prior values. Repeat with rst=0 at k+10 -> all outputs 0 next cycle.
- Back-to-back: start MULTU (3×4) asserted in the DONE cycle of a prior DIVU -> second done exactly 34 cycles later; HI=0, LO=12.
